// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and store-lane helpers for the data-memory access controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic       valid;
        owner_e     owner;
        logic [1:0] off;
        size_e      size;
        logic       uns;
    } rsp_t;

    function automatic logic [3:0] store_strobe(input size_e size, input logic [1:0] off);
        case (size)
            SIZE_B:  return 4'b0001 << off;
            SIZE_H:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Narrow stores replicate the datum across every lane; the strobe picks the live one.
    function automatic logic [31:0] store_data(input size_e size, input logic [31:0] wdata);
        case (size)
            SIZE_B:  return {4{wdata[7:0]}};
            SIZE_H:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core, DMA and RAM signal bundle for dmem_ctrl; slave is the controller view.
interface dmem_ctrl_if #(parameter int AW = 32);

    logic          core_req_i;
    logic          core_we_i;
    logic [AW-1:0] core_addr_i;
    logic [31:0]   core_wdata_i;
    logic [1:0]    core_size_i;
    logic          core_unsigned_i;
    logic          core_gnt_o;
    logic          core_stall_o;
    logic          core_err_o;
    logic          core_rvalid_o;
    logic [31:0]   core_rdata_o;

    logic          dma_req_i;
    logic          dma_we_i;
    logic [AW-1:0] dma_addr_i;
    logic [31:0]   dma_wdata_i;
    logic          dma_gnt_o;
    logic          dma_rvalid_o;
    logic [31:0]   dma_rdata_o;

    logic          ram_ce_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic [3:0]    ram_wstrb_o;
    logic [31:0]   ram_rdata_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i, core_size_i, core_unsigned_i,
        output core_gnt_o, core_stall_o, core_err_o, core_rvalid_o, core_rdata_o,
        input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
        output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
        output ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wstrb_o,
        input  ram_rdata_i
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i, core_size_i, core_unsigned_i,
        input  core_gnt_o, core_stall_o, core_err_o, core_rvalid_o, core_rdata_o,
        output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
        input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wstrb_o,
        output ram_rdata_i
    );

endinterface

// File: rtl/dmem_load_align.sv
// Load return path: shift the RAM word down to the addressed lane, then mask and extend.
module dmem_load_align
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        data = shifted;
        case (size)
            SIZE_B:  data = {{24{~uns & shifted[7]}}, shifted[7:0]};
            SIZE_H:  data = {{16{~uns & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: core/DMA arbitration, store lanes, load alignment.
// Define DMEM_CTRL_DMA_EN to build the DMA port and its starvation counter.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int AW         = 32,
    parameter int STARVE_MAX = 4
)(
    input logic         clk,
    input logic         rstn,
    dmem_ctrl_if.slave  bus
);

    size_e         core_size;
    logic          core_mis;
    logic          core_gnt;
    logic          core_acc;
    logic          dma_win;
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_wstrb;
    rsp_t          rsp;
    rsp_t          rsp_next;
    logic [31:0]   load_data;

    assign core_size = size_e'(bus.core_size_i);

    always_comb begin
        case (core_size)
            SIZE_B:  core_mis = 1'b0;
            SIZE_H:  core_mis = bus.core_addr_i[0];
            default: core_mis = |bus.core_addr_i[1:0];
        endcase
    end

`ifdef DMEM_CTRL_DMA_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             unused_dma;

    assign starved    = (starve_cnt == CNT_W'(STARVE_MAX));
    assign dma_win    = bus.dma_req_i & (~bus.core_req_i | starved);
    assign unused_dma = ^bus.dma_addr_i[1:0];

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (!bus.dma_req_i || dma_win) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_dma;

    assign dma_win    = 1'b0;
    assign unused_dma = ^{bus.dma_req_i, bus.dma_we_i, bus.dma_addr_i, bus.dma_wdata_i, STARVE_MAX[0]};
`endif

    // A misaligned core access is still granted; it burns the slot without touching the RAM.
    assign core_gnt = bus.core_req_i & ~dma_win;
    assign core_acc = core_gnt & ~core_mis;
    assign ram_ce   = dma_win | core_acc;

    // NOTE: every always_comb output gets a default first, otherwise idle paths infer latches.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wstrb = '0;
`ifdef DMEM_CTRL_DMA_EN
        if (dma_win) begin
            ram_we   = bus.dma_we_i;
            ram_addr = {bus.dma_addr_i[AW-1:2], 2'b00};
            if (bus.dma_we_i) begin
                ram_wdata = bus.dma_wdata_i;
                ram_wstrb = 4'b1111;
            end
        end else
`endif
        if (core_acc) begin
            ram_we   = bus.core_we_i;
            ram_addr = {bus.core_addr_i[AW-1:2], 2'b00};
            if (bus.core_we_i) begin
                ram_wdata = store_data(core_size, bus.core_wdata_i);
                ram_wstrb = store_strobe(core_size, bus.core_addr_i[1:0]);
            end
        end
    end

    always_comb begin
        rsp_next       = '0;
        rsp_next.valid = ram_ce & ~ram_we;
        rsp_next.owner = dma_win ? OWN_DMA : OWN_CORE;
        rsp_next.off   = dma_win ? 2'b00 : bus.core_addr_i[1:0];
        rsp_next.size  = dma_win ? SIZE_W : core_size;
        rsp_next.uns   = ~dma_win & bus.core_unsigned_i;
    end

    // NOTE: clearing valid on reset is what drops an in-flight read; the other fields are reset too for clean outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp <= '0;
        end else begin
            rsp <= rsp_next;
        end
    end

    dmem_load_align u_load_align (
        .rdata (bus.ram_rdata_i),
        .off   (rsp.off),
        .size  (rsp.size),
        .uns   (rsp.uns),
        .data  (load_data)
    );

    assign bus.core_gnt_o    = core_gnt;
    assign bus.core_stall_o  = bus.core_req_i & ~core_gnt;
    assign bus.core_err_o    = core_gnt & core_mis;
    assign bus.core_rvalid_o = rsp.valid & (rsp.owner == OWN_CORE);
    assign bus.core_rdata_o  = bus.core_rvalid_o ? load_data : 32'h0;

`ifdef DMEM_CTRL_DMA_EN
    assign bus.dma_gnt_o    = dma_win;
    assign bus.dma_rvalid_o = rsp.valid & (rsp.owner == OWN_DMA);
    assign bus.dma_rdata_o  = bus.dma_rvalid_o ? load_data : 32'h0;
`else
    assign bus.dma_gnt_o    = 1'b0;
    assign bus.dma_rvalid_o = 1'b0;
    assign bus.dma_rdata_o  = 32'h0;
`endif

    assign bus.ram_ce_o    = ram_ce;
    assign bus.ram_we_o    = ram_we;
    assign bus.ram_addr_o  = ram_addr;
    assign bus.ram_wdata_o = ram_wdata;
    assign bus.ram_wstrb_o = ram_wstrb;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: RAM model, response scoreboard, scenario tasks.
module tb_dmem_ctrl;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_ctrl_if #(.AW(32)) bus ();

    dmem_ctrl #(.AW(32), .STARVE_MAX(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Synchronous RAM model: contents seeded on the first edge, one-cycle read latency.
    logic [31:0] mem [0:255];
    logic [31:0] ram_q     = 32'h0;
    logic        mem_ready = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h40) return 32'h80FF7F01;
        if (i == 32'h41) return 32'hCAFEF00D;
        return (i * 32'h01000193) ^ 32'h9E3779B9;
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (bus.ram_ce_o) begin
            if (bus.ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_wstrb_o[b]) mem[bus.ram_addr_o[9:2]][b*8 +: 8] <= bus.ram_wdata_o[b*8 +: 8];
            end else begin
                ram_q <= mem[bus.ram_addr_o[9:2]];
            end
        end
    end

    assign bus.ram_rdata_i = ram_q;

    function automatic logic [31:0] exp_load(input logic [31:0] w, input int off,
                                             input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (size)
            2'd0: begin
                b = w[off*8 +: 8];
                return uns ? {24'h0, b} : {{24{b[7]}}, b};
            end
            2'd1: begin
                h = (off == 2) ? w[31:16] : w[15:0];
                return uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return w;
        endcase
    endfunction

    // Scoreboard of expected read responses, each due in a specific cycle.
    typedef struct {
        int          due;
        logic        owner;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    logic        mon_owner;
    logic [31:0] mon_got;
    logic [31:0] mon_oth;

    always @(negedge clk) begin
        if (bus.core_rvalid_o || bus.dma_rvalid_o) begin
            checks++;
            if (bus.core_rvalid_o && bus.dma_rvalid_o) begin
                errors++;
                $display("FAIL rsp_both cyc=%0d got core_rvalid=1 dma_rvalid=1 want one", cyc);
            end else if (sb.size() == 0 || sb[0].due != cyc) begin
                errors++;
                $display("FAIL rsp_unexpected cyc=%0d got rvalid want none", cyc);
            end else begin
                mon_e     = sb.pop_front();
                mon_owner = bus.dma_rvalid_o;
                mon_got   = mon_owner ? bus.dma_rdata_o : bus.core_rdata_o;
                mon_oth   = mon_owner ? bus.core_rdata_o : bus.dma_rdata_o;
                if (mon_owner !== mon_e.owner || mon_got !== mon_e.data || mon_oth !== 32'h0) begin
                    errors++;
                    $display("FAIL rsp_data cyc=%0d got owner=%b data=%h other=%h want owner=%b data=%h other=0",
                             cyc, mon_owner, mon_got, mon_oth, mon_e.owner, mon_e.data);
                end
            end
        end else if (sb.size() != 0 && sb[0].due == cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing cyc=%0d got no rvalid want owner=%b data=%h", cyc, sb[0].owner, sb[0].data);
            sb.delete(0);
        end
    end

    task automatic set_core(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        bus.core_req_i      = req;
        bus.core_we_i       = we;
        bus.core_addr_i     = addr;
        bus.core_wdata_i    = wdata;
        bus.core_size_i     = size;
        bus.core_unsigned_i = uns;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.dma_req_i   = req;
        bus.dma_we_i    = we;
        bus.dma_addr_i  = addr;
        bus.dma_wdata_i = wdata;
    endtask

    task automatic idle();
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic owner, input logic [31:0] data);
        sb.push_back('{cyc + 1, owner, data});
    endtask

    function automatic logic [139:0] outs_vec();
        return {bus.core_gnt_o, bus.core_stall_o, bus.core_err_o, bus.core_rvalid_o, bus.core_rdata_o,
                bus.dma_gnt_o, bus.dma_rvalid_o, bus.dma_rdata_o,
                bus.ram_ce_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o, bus.ram_wstrb_o};
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        checks++;
        if (outs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", outs_vec());
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        next();
    endtask

    task automatic test_loads();
        logic [31:0] a [8] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100, 32'h100, 32'h103, 32'h100};
        logic [1:0]  s [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1};
        logic        u [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] x [8] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h000080FF,
                               32'h80FF7F01, 32'h00000001, 32'hFFFFFF80, 32'h00007F01};
        for (int i = 0; i < 8; i++) begin
            set_core(1'b1, 1'b0, a[i], 32'h0, s[i], u[i]);
            expect_rsp(1'b0, x[i]);
            @(negedge clk);
            checks++;
            if ({bus.core_gnt_o, bus.core_stall_o, bus.core_err_o, bus.ram_ce_o, bus.ram_we_o, bus.ram_addr_o}
                !== {5'b10010, a[i] & ~32'h3}) begin
                errors++;
                $display("FAIL load_issue i=%0d got gnt=%b ce=%b we=%b addr=%h want gnt=1 ce=1 we=0 addr=%h",
                         i, bus.core_gnt_o, bus.ram_ce_o, bus.ram_we_o, bus.ram_addr_o, a[i] & ~32'h3);
            end
            next();
        end
        idle();
        next();
    endtask

    task automatic test_random_loads();
        int          idx;
        int          off;
        logic [1:0]  s;
        logic        u;
        logic [31:0] addr;
        for (int i = 0; i < 24; i++) begin
            idx  = int'($urandom_range(0, 63));
            s    = 2'($urandom_range(0, 2));
            u    = 1'($urandom_range(0, 1));
            off  = (s == 2'd0) ? int'($urandom_range(0, 3)) : (s == 2'd1) ? 2 * int'($urandom_range(0, 1)) : 0;
            addr = 32'(idx * 4 + off);
            set_core(1'b1, 1'b0, addr, 32'h0, s, u);
            expect_rsp(1'b0, exp_load(init_word(idx), off, s, u));
            next();
        end
        idle();
        next();
    endtask

    task automatic test_store();
        logic [31:0] a  [5] = '{32'h202, 32'h201, 32'h204, 32'h206, 32'h20B};
        logic [31:0] d  [5] = '{32'h1234ABCD, 32'h000000EE, 32'hDEADBEEF, 32'h00005678, 32'h00000077};
        logic [1:0]  s  [5] = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
        logic [3:0]  st [5] = '{4'b1100, 4'b0010, 4'b1111, 4'b1100, 4'b1000};
        logic [31:0] wd [5] = '{32'hABCDABCD, 32'hEEEEEEEE, 32'hDEADBEEF, 32'h56785678, 32'h77777777};
        logic [31:0] w80;
        logic [31:0] w82;
        for (int i = 0; i < 5; i++) begin
            set_core(1'b1, 1'b1, a[i], d[i], s[i], 1'b0);
            @(negedge clk);
            checks++;
            if ({bus.core_gnt_o, bus.core_err_o, bus.ram_ce_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_wstrb_o, bus.ram_wdata_o}
                !== {4'b1011, a[i] & ~32'h3, st[i], wd[i]}) begin
                errors++;
                $display("FAIL store_issue i=%0d got addr=%h strb=%b wdata=%h want addr=%h strb=%b wdata=%h",
                         i, bus.ram_addr_o, bus.ram_wstrb_o, bus.ram_wdata_o, a[i] & ~32'h3, st[i], wd[i]);
            end
            next();
        end
        idle();
        next();
        w80 = init_word(32'h80);
        w82 = init_word(32'h82);
        set_core(1'b1, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0);
        expect_rsp(1'b0, {16'hABCD, 8'hEE, w80[7:0]});
        next();
        set_core(1'b1, 1'b0, 32'h204, 32'h0, 2'd2, 1'b0);
        expect_rsp(1'b0, 32'h5678BEEF);
        next();
        set_core(1'b1, 1'b0, 32'h208, 32'h0, 2'd2, 1'b0);
        expect_rsp(1'b0, {8'h77, w82[23:0]});
        next();
        idle();
        next();
    endtask

    task automatic test_misaligned();
        logic [31:0] a [4] = '{32'h301, 32'h303, 32'h302, 32'h305};
        logic [1:0]  s [4] = '{2'd2, 2'd1, 2'd2, 2'd1};
        logic        w [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            set_core(1'b1, w[i], a[i], 32'hFFFFFFFF, s[i], 1'b0);
            set_dma(1'b1, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            checks++;
            if ({bus.core_gnt_o, bus.core_err_o, bus.core_stall_o, bus.ram_ce_o, bus.dma_gnt_o} !== 5'b11000) begin
                errors++;
                $display("FAIL misaligned i=%0d got gnt=%b err=%b stall=%b ce=%b dma_gnt=%b want 1 1 0 0 0",
                         i, bus.core_gnt_o, bus.core_err_o, bus.core_stall_o, bus.ram_ce_o, bus.dma_gnt_o);
            end
            next();
        end
        set_dma(1'b0, 1'b0, 32'h0, 32'h0);
        set_core(1'b1, 1'b0, 32'h302, 32'h0, 2'd1, 1'b0);
        expect_rsp(1'b0, exp_load(init_word(32'hC0), 2, 2'd1, 1'b0));
        @(negedge clk);
        checks++;
        if ({bus.core_gnt_o, bus.core_err_o, bus.ram_ce_o} !== 3'b101) begin
            errors++;
            $display("FAIL aligned_half got gnt=%b err=%b ce=%b want 1 0 1", bus.core_gnt_o, bus.core_err_o, bus.ram_ce_o);
        end
        next();
        idle();
        repeat (2) next();
    endtask

`ifdef DMEM_CTRL_DMA_EN
    task automatic test_starvation();
        logic        ed;
        logic [31:0] ea;
        logic [31:0] ew;
        for (int i = 0; i < 15; i++) begin
            ed = (i == 4) || (i == 13);
            ea = ed ? 32'h304 : 32'h300;
            ew = ed ? (32'hD0000000 | i) : (32'hC0000000 | i);
            set_core(1'b1, 1'b1, 32'h300, 32'hC0000000 | i, 2'd2, 1'b0);
            set_dma(i != 8, 1'b1, 32'h306, 32'hD0000000 | i);
            @(negedge clk);
            checks++;
            if ({bus.core_gnt_o, bus.dma_gnt_o, bus.core_stall_o, bus.ram_ce_o, bus.ram_we_o,
                 bus.ram_addr_o, bus.ram_wstrb_o, bus.ram_wdata_o}
                !== {~ed, ed, ed, 2'b11, ea, 4'b1111, ew}) begin
                errors++;
                $display("FAIL starve i=%0d got core_gnt=%b dma_gnt=%b stall=%b addr=%h wdata=%h want %b %b %b %h %h",
                         i, bus.core_gnt_o, bus.dma_gnt_o, bus.core_stall_o, bus.ram_addr_o, bus.ram_wdata_o,
                         ~ed, ed, ed, ea, ew);
            end
            next();
        end
        idle();
        next();
    endtask

    task automatic test_back_to_back();
        set_core(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        expect_rsp(1'b0, 32'h80FF7F01);
        @(negedge clk);
        checks++;
        if ({bus.core_gnt_o, bus.dma_gnt_o} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_c0 got core_gnt=%b dma_gnt=%b want 1 0", bus.core_gnt_o, bus.dma_gnt_o);
        end
        next();
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        set_dma(1'b1, 1'b0, 32'h106, 32'h0);
        expect_rsp(1'b1, 32'hCAFEF00D);
        @(negedge clk);
        checks++;
        if ({bus.core_rvalid_o, bus.dma_rvalid_o, bus.dma_gnt_o, bus.core_gnt_o, bus.ram_addr_o} !== {4'b1010, 32'h104}) begin
            errors++;
            $display("FAIL b2b_c1 got crv=%b drv=%b dgnt=%b cgnt=%b addr=%h want 1 0 1 0 00000104",
                     bus.core_rvalid_o, bus.dma_rvalid_o, bus.dma_gnt_o, bus.core_gnt_o, bus.ram_addr_o);
        end
        next();
        idle();
        @(negedge clk);
        checks++;
        if ({bus.core_rvalid_o, bus.dma_rvalid_o} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_c2 got crv=%b drv=%b want 0 1", bus.core_rvalid_o, bus.dma_rvalid_o);
        end
        next();
        next();
    endtask
`else
    task automatic test_dma_off();
        for (int i = 0; i < 6; i++) begin
            set_core(1'b1, 1'b0, 32'h104, 32'h0, 2'd2, 1'b0);
            set_dma(1'b1, 1'b0, 32'h100, 32'h0);
            expect_rsp(1'b0, 32'hCAFEF00D);
            @(negedge clk);
            checks++;
            if ({bus.core_gnt_o, bus.core_stall_o, bus.dma_gnt_o, bus.dma_rvalid_o, bus.dma_rdata_o} !== {4'b1000, 32'h0}) begin
                errors++;
                $display("FAIL dma_off i=%0d got cgnt=%b stall=%b dgnt=%b drv=%b drd=%h want 1 0 0 0 0",
                         i, bus.core_gnt_o, bus.core_stall_o, bus.dma_gnt_o, bus.dma_rvalid_o, bus.dma_rdata_o);
            end
            next();
        end
        idle();
        repeat (2) next();
    endtask
`endif

    task automatic test_reset_mid_read();
        set_core(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        @(negedge clk);
        checks++;
        if ({bus.core_gnt_o, bus.ram_ce_o} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_issue got gnt=%b ce=%b want 1 1", bus.core_gnt_o, bus.ram_ce_o);
        end
        #1 rstn = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (outs_vec() !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got=%h want=0", outs_vec());
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.core_rvalid_o, bus.dma_rvalid_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_rvalid got crv=%b drv=%b want 0 0", bus.core_rvalid_o, bus.dma_rvalid_o);
        end
        repeat (3) next();
    endtask

    initial begin
        test_reset();
        test_loads();
        test_random_loads();
        test_store();
        test_misaligned();
`ifdef DMEM_CTRL_DMA_EN
        test_starvation();
        test_back_to_back();
`else
        test_dma_off();
`endif
        test_reset_mid_read();
        repeat (2) next();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the pipeline load/store path (feeding the MEM stage) and the single-ported synchronous data RAM. It arbitrates the RAM between the core port and a secondary word-wide DMA/debug port. It generates byte strobes and replicated write data for stores, and aligns and sign-extends load data on return. It stalls the core when the core loses arbitration.

## Interface
- `AW`, 32: address width
- `STARVE_MAX`, 4: consecutive lost cycles before DMA is forced a grant

Ports:
- `clk` in 1: clock
- `rstn` in 1: asynchronous active-low reset
- `core_req_i`, `core_we_i` in 1: core access request, write enable
- `core_addr_i` in AW: byte address
- `core_wdata_i` in 32: store data, right-justified
- `core_size_i` in 2: 00 byte, 01 half, 10 word
- `core_unsigned_i` in 1: zero-extend load
- `core_gnt_o` out 1: core request accepted this cycle
- `core_stall_o` out 1: `core_req_i & ~core_gnt_o`
- `core_err_o` out 1: misaligned access, pulse
- `core_rvalid_o` out 1, `core_rdata_o` out 32: load response
- `dma_req_i`, `dma_we_i` in 1; `dma_addr_i` in AW; `dma_wdata_i` in 32: word-only port
- `dma_gnt_o`, `dma_rvalid_o` out 1; `dma_rdata_o` out 32
- `ram_ce_o`, `ram_we_o` out 1; `ram_addr_o` out AW (word-aligned); `ram_wdata_o` out 32; `ram_wstrb_o` out 4
- `ram_rdata_i` in 32: read data, valid one cycle after `ram_ce_o & ~ram_we_o`

## Operation
- Arbitration is combinational in the request cycle. The core has priority by default.
- Starvation counter: increments on each cycle where `dma_req_i=1` and the DMA is not granted. It clears on a DMA grant or when `dma_req_i=0`. When it reaches `STARVE_MAX`, the DMA wins the next cycle.
- A DMA address is word-aligned by truncation. DMA strobe is always 1111.
- Stores:
  - byte: strobe `1<<addr[1:0]`, data byte replicated x4
  - half: strobe `addr[1]?1100:0011`, data half replicated x2
  - word: strobe 1111
- Misaligned accesses are half with `addr[0]=1` and word with `addr[1:0]!=0`, on the core port only.
  - `core_gnt_o=1` and `core_err_o=1` in the same cycle.
  - `ram_ce_o=0`, and no response is returned.
  - A misaligned request still consumes the cycle: the DMA is not granted that cycle.
- Read response pipeline registers: `rsp_valid`, `rsp_owner` (core/dma), `rsp_off[1:0]`, `rsp_size`, `rsp_uns`.
- The next cycle, `ram_rdata_i` is shifted by `rsp_off*8`, masked to size, then sign- or zero-extended. It is routed to the owner's rdata/rvalid. The non-owner's rdata is 0.
- Writes return no response.

## Timing
- Grant, RAM controls and `core_err_o` are combinational in the request cycle.
- Read latency is 1 cycle: rvalid is registered.
- Back-to-back reads are supported: a new grant may be issued in the response cycle, giving full throughput.
- Simultaneous core and DMA requests: exactly one grant. The core wins unless the counter equals `STARVE_MAX`.
- The counter saturates at `STARVE_MAX`.
- Reset values:
  - `rsp_valid=0`, counter=0.
  - All outputs read 0 with no requests: gnt, stall, err, rvalid, rdata, ram_ce, ram_we, ram_addr, ram_wdata and ram_wstrb.
- Reset asserted between a read grant and its response: the response is dropped, and no rvalid appears after release.

## Configuration
- `DMEM_CTRL_DMA_EN` defined: DMA port and starvation counter are present as described.
- `DMEM_CTRL_DMA_EN` undefined:
  - `dma_gnt_o`, `dma_rvalid_o` and `dma_rdata_o` are tied to 0, and DMA inputs are ignored.
  - No counter exists. The core is granted on every request, so `core_stall_o` is constantly 0.

## Structure
- Add the size encodings (`SIZE_B`, `SIZE_H`, `SIZE_W`) and the owner encodings to the shared defines file beside the existing bus-width macros.
- One sub-module, `dmem_load_align`: combinational shift, mask and extend from (`ram_rdata_i`, off, size, uns) to 32-bit data.

## Test plan
- **Signed/unsigned byte load:** RAM word 0x80FF7F01 at 0x100.
  - Core LB 0x102 -> `core_rvalid_o` next cycle, `core_rdata_o`=0xFFFFFFFF.
  - LBU 0x102 -> 0x000000FF.
  - LH 0x102 -> 0xFFFF80FF.
- **Half store:** core SH 0x202, wdata 0x1234ABCD -> `ram_addr_o`=0x200, `ram_wstrb_o`=1100, `ram_wdata_o`=0xABCDABCD, no rvalid.
- **Starvation:** core_req and dma_req held high from cycle 0, `STARVE_MAX`=4.
  - Core granted cycles 0-3.
  - DMA granted cycle 4, with `core_stall_o`=1 in cycle 4.
  - Counter clears, and core is granted cycle 5.
- **Misaligned load:** core LW 0x301 -> `core_err_o`=1 and `core_gnt_o`=1 in the same cycle, `ram_ce_o`=0, no rvalid the following cycle.
- **Back-to-back ownership:** core read 0x100 in cycle 0, DMA read 0x104 in cycle 1 -> `core_rvalid_o` in cycle 1 with word 0x100 data, `dma_rvalid_o` in cycle 2 with word 0x104 data. Non-owner rvalid stays 0 throughout.
- **Reset mid-read / macro off:**
  - `rstn` low the cycle after a core read grant -> all outputs 0, no rvalid after release.
  - With `DMEM_CTRL_DMA_EN` undefined -> `dma_gnt_o`=0 under `dma_req_i`=1.
